// File: rtl/fft_pkg.sv
// Shared constants for the FFT peak finder: float field positions and FSM states.
package fft_pkg;

    localparam int FP_W    = 32;
    localparam int EXP_MSB = 30;
    localparam int EXP_LSB = 23;
    localparam int MAN_MSB = 22;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fp_mag_ge.sv
// Magnitude >= compare of two single-precision floats on raw bit fields.
// Sign is ignored. NaN, Inf and denormals get no special treatment.
module fp_mag_ge
    import fft_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic            ge
);

    logic [EXP_MSB-EXP_LSB:0] exp_a, exp_b;
    logic [MAN_MSB:0]         man_a, man_b;

    assign exp_a = a[EXP_MSB:EXP_LSB];
    assign exp_b = b[EXP_MSB:EXP_LSB];
    assign man_a = a[MAN_MSB:0];
    assign man_b = b[MAN_MSB:0];

    // The exponent decides first. The mantissa only breaks an exponent tie.
    assign ge = (exp_a > exp_b) || ((exp_a == exp_b) && (man_a >= man_b));

endmodule

// File: rtl/fft_peak_finder.sv
// Streaming peak detector: scans one frame of N_POINTS float magnitudes and
// reports the largest value and its bin index. A one-cycle done pulse marks the result.
module fft_peak_finder
    import fft_pkg::*;
#(
    parameter int N_POINTS = 64,
    parameter int IDX_W    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FP_W-1:0]  in_data,
    output logic             busy,
    output logic [FP_W-1:0]  peak_val,
    output logic [IDX_W-1:0] peak_idx,
    output logic             done
);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] cnt;
    logic [IDX_W-1:0] best_idx;
    logic [FP_W-1:0]  best_val;
    logic             accept;
    logic             last;
    logic             ge;
    logic             take;

    fp_mag_ge u_ge (
        .a  (in_data),
        .b  (best_val),
        .ge (ge)
    );

    assign accept = in_valid && in_ready;
    assign last   = (cnt == IDX_W'(N_POINTS - 1));
    // Bin 0 seeds the running best. Later bins replace it on >=, so the latest tie wins.
    assign take   = (cnt == '0) || ge;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (accept && last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The handshake and status outputs are registered from the next state.
    // in_ready therefore never depends combinationally on in_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt == SCAN);
            busy     <= (state_nxt != IDLE);
            done     <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            best_val <= '0;
            best_idx <= '0;
            peak_val <= '0;
            peak_idx <= '0;
        end else if (state == IDLE && start) begin
            cnt      <= '0;
            best_val <= '0;
            best_idx <= '0;
        end else if (accept) begin
            cnt <= cnt + 1'b1;
            if (take) begin
                best_val <= in_data;
                best_idx <= cnt;
            end
            // The last beat's compare result goes straight to the outputs.
            if (last) begin
                peak_val <= take ? in_data : best_val;
                peak_idx <= take ? cnt : best_idx;
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_finder.sv
// Self-checking bench for fft_peak_finder with N_POINTS=4: directed vectors,
// hand-written corner sequences and random frames checked against a reference peak model.
module tb_fft_peak_finder;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          busy;
    logic [31:0]   peak_val;
    logic [IW-1:0] peak_idx;
    logic          done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0][31:0] d;
        int                 gap;
        int                 start_at;
        bit                 junk;
        logic [31:0]        exp_val;
        int                 exp_idx;
        string              name;
    } vec_t;

    always #5 clk = ~clk;

    fft_peak_finder #(.N_POINTS(N), .IDX_W(IW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .busy     (busy),
        .peak_val (peak_val),
        .peak_idx (peak_idx),
        .done     (done)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [N-1:0][31:0] mk(input logic [31:0] a, b, c, e);
        logic [N-1:0][31:0] r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = e;
        return r;
    endfunction

    // Reference model: the largest magnitude, with the sign bit stripped. Ties go to the later bin.
    task automatic ref_peak(input logic [N-1:0][31:0] d, output logic [31:0] v, output int idx);
        v   = d[0];
        idx = 0;
        for (int k = 1; k < N; k++) begin
            if ({1'b0, d[k][30:0]} >= {1'b0, v[30:0]}) begin
                v   = d[k];
                idx = k;
            end
        end
    endtask

    // Drives a full frame from IDLE and checks the handshake, the done timing and the return to IDLE.
    task automatic run_frame(input logic [N-1:0][31:0] d, input int gap, input int start_at,
                             input bit junk, input string tag);
        if (junk) begin
            in_valid = 1'b1;
            in_data  = 32'h7F000000;
            @(negedge clk);
            chk({tag, "/ready_idle"}, {31'd0, in_ready}, 32'd0);
            in_valid = 1'b0;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "/ready_scan"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "/busy_scan"}, {31'd0, busy}, 32'd1);
        for (int i = 0; i < N; i++) begin
            chk({tag, "/done_early"}, {31'd0, done}, 32'd0);
            in_valid = 1'b1;
            in_data  = d[i];
            start    = (i == start_at);
            @(negedge clk);
            start    = 1'b0;
            in_valid = 1'b0;
            if (i < N - 1) repeat (gap) @(negedge clk);
        end
        chk({tag, "/done_pulse"}, {31'd0, done}, 32'd1);
        chk({tag, "/ready_done"}, {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk({tag, "/done_clear"}, {31'd0, done}, 32'd0);
        chk({tag, "/busy_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        vec_t               vecs[5];
        logic [31:0]        pool[4];
        logic [N-1:0][31:0] d;
        logic [31:0]        ev;
        int                 ei;

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        @(negedge clk);
        chk("rst/ready", {31'd0, in_ready}, 32'd0);
        chk("rst/busy", {31'd0, busy}, 32'd0);
        chk("rst/done", {31'd0, done}, 32'd0);
        chk("rst/val", peak_val, 32'd0);
        chk("rst/idx", {30'd0, peak_idx}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        vecs[0] = '{mk(32'h3F000000, 32'h3F800000, 32'h3FC00000, 32'h40000000), 0, -1, 1'b0,
                    32'h40000000, 3, "ascending"};
        vecs[1] = '{mk(32'h3F800000, 32'hC0400000, 32'h40000000, 32'h3F000000), 0, -1, 1'b0,
                    32'hC0400000, 1, "sign"};
        vecs[2] = '{mk(32'h40000000, 32'h3F800000, 32'h40000000, 32'h3F000000), 2, -1, 1'b0,
                    32'h40000000, 2, "tie_bubble"};
        vecs[3] = '{mk(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000), 0, -1, 1'b1,
                    32'h3F800000, 3, "gating"};
        vecs[4] = '{mk(32'h3F000000, 32'h40400000, 32'h3F800000, 32'h3FC00000), 1, 2, 1'b0,
                    32'h40400000, 1, "start_busy"};

        foreach (vecs[v]) begin
            run_frame(vecs[v].d, vecs[v].gap, vecs[v].start_at, vecs[v].junk, vecs[v].name);
            chk({vecs[v].name, "/val"}, peak_val, vecs[v].exp_val);
            chk({vecs[v].name, "/idx"}, {30'd0, peak_idx}, vecs[v].exp_idx);
        end

        // Reset mid-frame: the outputs drop at once with no clock edge, and no done follows.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = 32'h7F000000;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst/ready", {31'd0, in_ready}, 32'd0);
        chk("midrst/busy", {31'd0, busy}, 32'd0);
        chk("midrst/done", {31'd0, done}, 32'd0);
        chk("midrst/val", peak_val, 32'd0);
        chk("midrst/idx", {30'd0, peak_idx}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst/no_done", {31'd0, done}, 32'd0);
        run_frame(vecs[0].d, 0, -1, 1'b0, "after_rst");
        chk("after_rst/val", peak_val, 32'h40000000);
        chk("after_rst/idx", {30'd0, peak_idx}, 32'd3);

        // Random frames: a small value pool forces ties and sign flips.
        pool[0] = 32'h3F800000; pool[1] = 32'hBF800000;
        pool[2] = 32'h40000000; pool[3] = 32'h3F800001;
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < N; i++)
                d[i] = ($urandom_range(0, 2) == 0) ? $urandom() : pool[$urandom_range(0, 3)];
            ref_peak(d, ev, ei);
            run_frame(d, $urandom_range(0, 2), ($urandom_range(0, 3) == 0) ? 1 : -1,
                      ($urandom_range(0, 3) == 0), "rand");
            chk("rand/val", peak_val, ev);
            chk("rand/idx", {30'd0, peak_idx}, ei);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
